// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational NZCV ALU, with registered responses
// and a private status register per requester. Optional grant locking: ALU_ARB_LOCK_EN.
module alu_share_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int LOCK_MAX   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic [3:0]  r0_exe_cmd,
  input  logic [31:0] r0_val1,
  input  logic [31:0] r0_val2,
  input  logic        r0_s,
  input  logic        r0_lock,
  output logic        r0_rsp_valid,
  input  logic        r0_rsp_ready,
  output logic [31:0] r0_result,
  output logic [3:0]  r0_status,
  output logic [3:0]  r0_sr,
  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic [3:0]  r1_exe_cmd,
  input  logic [31:0] r1_val1,
  input  logic [31:0] r1_val2,
  input  logic        r1_s,
  input  logic        r1_lock,
  output logic        r1_rsp_valid,
  input  logic        r1_rsp_ready,
  output logic [31:0] r1_result,
  output logic [3:0]  r1_status,
  output logic [3:0]  r1_sr
);

  logic [1:0]  req_valid, rsp_ready, rsp_valid, elig, grant;
  logic        last_grant, gsel, lock_hold, lock_drop, lock_owner;
  logic [3:0]  alu_cmd, alu_status;
  logic [31:0] alu_val1, alu_val2, alu_res;
  logic        alu_cin, alu_c, alu_v, alu_def;
  logic [32:0] sum;

  assign req_valid = {r1_req_valid, r0_req_valid};
  assign rsp_ready = {r1_rsp_ready, r0_rsp_ready};
  assign rsp_valid = {r1_rsp_valid, r0_rsp_valid};
  assign elig      = req_valid & (~rsp_valid | rsp_ready);

`ifdef ALU_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [1:0]    lock_in;
  logic          lock_active;
  logic [CW-1:0] lock_cnt, lock_cnt_inc;

  assign lock_in      = {r1_lock, r0_lock};
  assign lock_hold    = lock_active & req_valid[lock_owner];
  assign lock_drop    = lock_active & ~req_valid[lock_owner];
  assign lock_cnt_inc = lock_cnt + CW'(1);

  // The grant that takes the lock counts as the first locked grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
      lock_cnt    <= '0;
    end else if (lock_hold) begin
      if (grant[lock_owner]) begin
        if (!lock_in[lock_owner] || lock_cnt_inc == CW'(LOCK_MAX)) begin
          lock_active <= 1'b0;
          lock_cnt    <= '0;
        end else begin
          lock_cnt <= lock_cnt_inc;
        end
      end
    end else if ((|grant) && lock_in[gsel]) begin
      lock_owner  <= gsel;
      lock_cnt    <= CW'(1);
      lock_active <= (LOCK_MAX > 1);
    end else begin
      lock_active <= 1'b0;
      lock_cnt    <= '0;
    end
  end
`else
  logic unused_lock;
  localparam int unused_lock_max = LOCK_MAX;
  assign unused_lock = r0_lock ^ r1_lock;
  assign lock_hold   = 1'b0;
  assign lock_drop   = 1'b0;
  assign lock_owner  = 1'b0;
`endif

  always_comb begin
    grant = 2'b00;
    if (lock_hold) begin
      grant = lock_owner ? {elig[1], 1'b0} : {1'b0, elig[0]};
    end else if (elig == 2'b11) begin
      if (FIXED_PRIO != 0 || last_grant) grant = 2'b01;
      else                               grant = 2'b10;
    end else begin
      grant = elig;
    end
    if (!rst) grant = 2'b00;
  end

  assign r0_req_ready = grant[0];
  assign r1_req_ready = grant[1];
  assign gsel         = grant[1];

  assign alu_cmd  = gsel ? r1_exe_cmd : r0_exe_cmd;
  assign alu_val1 = gsel ? r1_val1    : r0_val1;
  assign alu_val2 = gsel ? r1_val2    : r0_val2;
  assign alu_cin  = gsel ? r1_sr[1]   : r0_sr[1];

  // Subtraction follows ARM convention: C = no borrow, SBC = a + ~b + C.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_def = 1'b0;
    case (alu_cmd)
      4'b0001: alu_res = alu_val2;
      4'b1001: alu_res = ~alu_val2;
      4'b0010, 4'b0011: begin
        sum     = {1'b0, alu_val1} + {1'b0, alu_val2}
                + {32'd0, (alu_cmd[0] & alu_cin)};
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = (alu_val1[31] == alu_val2[31]) && (sum[31] != alu_val1[31]);
      end
      4'b0100, 4'b0101: begin
        sum     = {1'b0, alu_val1} + {1'b0, ~alu_val2}
                + {32'd0, (alu_cmd[0] ? alu_cin : 1'b1)};
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = (alu_val1[31] != alu_val2[31]) && (sum[31] != alu_val1[31]);
      end
      4'b0110: alu_res = alu_val1 & alu_val2;
      4'b0111: alu_res = alu_val1 | alu_val2;
      4'b1000: alu_res = alu_val1 ^ alu_val2;
      default: alu_def = 1'b1;
    endcase
  end

  assign alu_status = alu_def ? 4'b0100
                              : {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           last_grant <= 1'b1;
    else if (|grant)    last_grant <= gsel;
    else if (lock_drop) last_grant <= lock_owner;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0_rsp_valid <= 1'b0;
      r0_result    <= '0;
      r0_status    <= '0;
      r0_sr        <= '0;
    end else if (grant[0]) begin
      r0_rsp_valid <= 1'b1;
      r0_result    <= alu_res;
      r0_status    <= alu_status;
      if (r0_s) r0_sr <= alu_status;
    end else if (r0_rsp_ready) begin
      r0_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_rsp_valid <= 1'b0;
      r1_result    <= '0;
      r1_status    <= '0;
      r1_sr        <= '0;
    end else if (grant[1]) begin
      r1_rsp_valid <= 1'b1;
      r1_result    <= alu_res;
      r1_status    <= alu_status;
      if (r1_s) r1_sr <= alu_status;
    end else if (r1_rsp_ready) begin
      r1_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: single op, round-robin, carry chain,
// backpressure, async reset and lock behaviour (expectations depend on ALU_ARB_LOCK_EN).
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req_valid, r0_req_ready, r0_s, r0_lock, r0_rsp_valid, r0_rsp_ready;
  logic [3:0]  r0_exe_cmd, r0_status, r0_sr;
  logic [31:0] r0_val1, r0_val2, r0_result;
  logic        r1_req_valid, r1_req_ready, r1_s, r1_lock, r1_rsp_valid, r1_rsp_ready;
  logic [3:0]  r1_exe_cmd, r1_status, r1_sr;
  logic [31:0] r1_val1, r1_val2, r1_result;

  int   tests = 0;
  int   fails = 0;
  logic g;
  logic [3:0] exp_pat;

  always #5 clk = ~clk;

  alu_share_arbiter #(.FIXED_PRIO(0), .LOCK_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_exe_cmd(r0_exe_cmd),
    .r0_val1(r0_val1), .r0_val2(r0_val2), .r0_s(r0_s), .r0_lock(r0_lock),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_result(r0_result),
    .r0_status(r0_status), .r0_sr(r0_sr),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_exe_cmd(r1_exe_cmd),
    .r1_val1(r1_val1), .r1_val2(r1_val2), .r1_s(r1_s), .r1_lock(r1_lock),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_result(r1_result),
    .r1_status(r1_status), .r1_sr(r1_sr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r0_req_valid = 1'b1; r0_exe_cmd = 4'd0; r0_val1 = '0; r0_val2 = '0;
    r0_s = 1'b0; r0_lock = 1'b0; r0_rsp_ready = 1'b0;
    r1_req_valid = 1'b0; r1_exe_cmd = 4'd0; r1_val1 = '0; r1_val2 = '0;
    r1_s = 1'b0; r1_lock = 1'b0; r1_rsp_ready = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("reset_r0_ready", r0_req_ready, 0);
    check("reset_r0_rsp_valid", r0_rsp_valid, 0);
    check("reset_r0_result", r0_result, 0);
    check("reset_r1_sr", r1_sr, 0);
    step;
    check("reset_hold_rsp_valid", r0_rsp_valid, 0);
    rst = 1'b1;

    // Single ADD 5 + 7
    r0_exe_cmd = 4'b0010; r0_val1 = 32'd5; r0_val2 = 32'd7; r0_s = 1'b1;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    #1;
    check("add_r0_ready", r0_req_ready, 1);
    check("add_r1_ready", r1_req_ready, 0);
    step;
    check("add_rsp_valid", r0_rsp_valid, 1);
    check("add_result", r0_result, 12);
    check("add_status", r0_status, 4'b0000);
    check("add_r0_sr", r0_sr, 4'b0000);
    check("add_r1_sr", r1_sr, 4'b0000);
    check("add_r1_rsp_valid", r1_rsp_valid, 0);
    r0_req_valid = 1'b0;
    step;
    check("drain_rsp_valid", r0_rsp_valid, 0);
    check("drain_result_held", r0_result, 12);

    // Round-robin conflict; r0 won last, so r1 goes first
    r0_exe_cmd = 4'b0001; r0_val2 = 32'hA; r0_s = 1'b0; r0_req_valid = 1'b1;
    r1_exe_cmd = 4'b0001; r1_val2 = 32'hB; r1_s = 1'b0; r1_req_valid = 1'b1;
    g = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_r0_ready", r0_req_ready, !g);
      check("rr_r1_ready", r1_req_ready, g);
      step;
      check("rr_r0_rsp_valid", r0_rsp_valid, !g);
      check("rr_r1_rsp_valid", r1_rsp_valid, g);
      if (g) check("rr_r1_result", r1_result, 32'hB);
      else   check("rr_r0_result", r0_result, 32'hA);
      g = ~g;
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    step;

    // Carry chain
    r1_exe_cmd = 4'b0010; r1_val1 = 32'hFFFF_FFFF; r1_val2 = 32'd1; r1_s = 1'b1;
    r1_req_valid = 1'b1;
    #1;
    check("cc_add_r1_ready", r1_req_ready, 1);
    step;
    check("cc_add_result", r1_result, 0);
    check("cc_add_status", r1_status, 4'b0110);
    check("cc_add_r1_sr", r1_sr, 4'b0110);
    check("cc_add_r0_sr", r0_sr, 4'b0000);
    r1_exe_cmd = 4'b0011; r1_val1 = '0; r1_val2 = '0;
    r0_exe_cmd = 4'b0011; r0_val1 = '0; r0_val2 = '0; r0_s = 1'b1; r0_req_valid = 1'b1;
    #1;
    check("cc_conflict_r0_ready", r0_req_ready, 1);
    check("cc_conflict_r1_ready", r1_req_ready, 0);
    step;
    check("cc_r0_adc_result", r0_result, 0);
    check("cc_r0_adc_status", r0_status, 4'b0100);
    check("cc_r0_sr", r0_sr, 4'b0100);
    check("cc_r1_sr_isolated", r1_sr, 4'b0110);
    r0_req_valid = 1'b0;
    #1;
    check("cc_r1_adc_ready", r1_req_ready, 1);
    step;
    check("cc_r1_adc_result", r1_result, 1);
    check("cc_r1_adc_status", r1_status, 4'b0000);
    check("cc_r1_sr_after", r1_sr, 4'b0000);
    r1_req_valid = 1'b0; r1_s = 1'b0;

    // Backpressure on r0
    r0_rsp_ready = 1'b0; r0_exe_cmd = 4'b0001; r0_val2 = 32'h55; r0_s = 1'b0;
    r0_req_valid = 1'b1;
    #1;
    check("bp_first_r0_ready", r0_req_ready, 1);
    step;
    check("bp_r0_rsp_valid", r0_rsp_valid, 1);
    check("bp_r0_result", r0_result, 32'h55);
    r0_val2 = 32'h66;
    r1_exe_cmd = 4'b0001; r1_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r1_val2 = 32'h100 + i;
      #1;
      check("bp_r0_ready_blocked", r0_req_ready, 0);
      check("bp_r1_ready", r1_req_ready, 1);
      step;
      check("bp_r0_hold_valid", r0_rsp_valid, 1);
      check("bp_r0_hold_result", r0_result, 32'h55);
      check("bp_r1_rsp_valid", r1_rsp_valid, 1);
      check("bp_r1_result", r1_result, 32'h100 + i);
    end
    r0_rsp_ready = 1'b1; r1_val2 = 32'h200;
    #1;
    check("bp_release_r0_ready", r0_req_ready, 1);
    check("bp_release_r1_ready", r1_req_ready, 0);
    step;
    check("bp_refill_valid", r0_rsp_valid, 1);
    check("bp_refill_result", r0_result, 32'h66);
    check("bp_r1_drained", r1_rsp_valid, 0);
    r1_req_valid = 1'b0;

    // Async reset between edges with an s=1 op pending
    r0_exe_cmd = 4'b0010; r0_val1 = 32'hFFFF_FFFF; r0_val2 = 32'd1; r0_s = 1'b1;
    #3 rst = 1'b0;
    #1;
    check("arst_rsp_valid", r0_rsp_valid, 0);
    check("arst_result", r0_result, 0);
    check("arst_status", r0_status, 0);
    check("arst_r0_sr", r0_sr, 0);
    check("arst_r0_ready", r0_req_ready, 0);
    step;
    check("arst_no_sr_update", r0_sr, 0);
    rst = 1'b1;

    // Post-reset conflict, r0 requesting a lock
`ifdef ALU_ARB_LOCK_EN
    exp_pat = 4'b1000;
`else
    exp_pat = 4'b1010;
`endif
    r0_exe_cmd = 4'b0001; r0_s = 1'b0; r0_lock = 1'b1;
    r1_exe_cmd = 4'b0001; r1_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("lock_r0_ready", r0_req_ready, !exp_pat[i]);
      check("lock_r1_ready", r1_req_ready, exp_pat[i]);
      step;
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0; r0_lock = 1'b0;
    step;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
